// File: rtl/bound_add_sched.sv
// Control schedule for the Sobel boundary-padding datapath: turns input video sync into
// line-buffer strobes, pad flags and row/column indices for the (IH+2R)x(IW+2R) extended frame.
module bound_add_sched #(
    parameter int unsigned KSZ     = 3,
    parameter int unsigned IW      = 4,
    parameter int unsigned IH      = 2,
    parameter int unsigned H_TOTAL = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din_vsync,
    input  logic        din_hsync,
    output logic        buf_wr,
    output logic        buf_rd,
    output logic        pad_row,
    output logic        pad_col,
    output logic        dout_vsync,
    output logic        dout_hsync,
    output logic [11:0] out_row,
    output logic [11:0] out_col,
    output logic        frame_err
);

    localparam int unsigned R  = (KSZ - 1) / 2;
    localparam int unsigned OW = IW + 2 * R;
    localparam int unsigned OH = IH + 2 * R;
    localparam int unsigned CW = 12;
    localparam int unsigned HW = $clog2(H_TOTAL + 1);

    localparam logic [CW-1:0] R_C     = CW'(R);
    localparam logic [CW-1:0] IW_C    = CW'(IW);
    localparam logic [CW-1:0] IH_C    = CW'(IH);
    localparam logic [CW-1:0] OH_C    = CW'(OH);
    localparam logic [CW-1:0] OW_LAST = CW'(OW - 1);
    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_LINE,
        S_LINE,
        S_GAP,
        S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   row, row_nxt;
    logic [CW-1:0]   col, col_nxt;
    logic [HW-1:0]   h, h_nxt;
    logic            vsync_d, hsync_d;
    logic            wr_line;
    logic            vs_rise, vs_fall, hs_rise;
    logic            abort, accept;

    logic            line_nxt;
    logic            dout_vsync_nxt, buf_wr_nxt, buf_rd_nxt;
    logic            pad_row_nxt, pad_col_nxt, frame_err_nxt;
    logic [CW-1:0]   out_row_nxt, out_col_nxt;

    assign vs_rise = din_vsync & ~vsync_d;
    assign vs_fall = ~din_vsync & vsync_d;
    assign hs_rise = din_hsync & ~hsync_d;
    // Truncated frame: sync dropped before all real input lines arrived.
    assign abort   = vs_fall & ((state == S_WAIT_LINE) | ((state == S_LINE) & (row < IH_C)));
    assign accept  = (state == S_WAIT_LINE) & hs_rise & ~abort;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and counter update logic
    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        col_nxt   = col;
        h_nxt     = h;
        case (state)
            S_IDLE: begin
                if (vs_rise) begin
                    state_nxt = S_WAIT_LINE;
                    row_nxt   = '0;
                end
            end
            S_WAIT_LINE: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (hs_rise) begin
                    state_nxt = S_LINE;
                    col_nxt   = '0;
                    h_nxt     = '0;
                end
            end
            S_LINE: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else begin
                    col_nxt = col + CW'(1);
                    h_nxt   = h + HW'(1);
                    if (col == OW_LAST) begin
                        if (row + CW'(1) < IH_C) begin
                            state_nxt = S_WAIT_LINE;
                            row_nxt   = row + CW'(1);
                        end else if (row + CW'(1) < OH_C) begin
                            state_nxt = S_GAP;
                            row_nxt   = row + CW'(1);
                        end else begin
                            state_nxt = S_DONE;
                        end
                    end
                end
            end
            S_GAP: begin
                // Generated lines keep the input line period exactly.
                if (h == H_LAST) begin
                    state_nxt = S_LINE;
                    col_nxt   = '0;
                    h_nxt     = '0;
                end else begin
                    h_nxt = h + HW'(1);
                end
            end
            S_DONE: begin
                if (!din_vsync) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode, evaluated on the upcoming state so every output can be registered
    always_comb begin
        line_nxt       = (state_nxt == S_LINE);
        dout_vsync_nxt = (state_nxt != S_IDLE) & (state != S_DONE);
        pad_row_nxt    = line_nxt & ((row_nxt < R_C) | (row_nxt >= R_C + IH_C));
        pad_col_nxt    = line_nxt & ((col_nxt < R_C) | (col_nxt >= R_C + IW_C));
        buf_rd_nxt     = line_nxt & (row_nxt >= R_C) & (row_nxt < R_C + IH_C)
                                  & (col_nxt >= R_C) & (col_nxt < R_C + IW_C);
        out_row_nxt    = line_nxt ? row_nxt : '0;
        out_col_nxt    = line_nxt ? col_nxt : '0;
        buf_wr_nxt     = din_hsync & ~abort & (accept | wr_line);
        frame_err_nxt  = abort | (hs_rise & ((state == S_LINE) | (state == S_GAP) | (state == S_DONE)));
    end

    // Counters, sync history and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row        <= '0;
            col        <= '0;
            h          <= '0;
            // Sync history resets high so a sync already active at reset release is not an edge.
            vsync_d    <= 1'b1;
            hsync_d    <= 1'b1;
            wr_line    <= 1'b0;
            buf_wr     <= 1'b0;
            buf_rd     <= 1'b0;
            pad_row    <= 1'b0;
            pad_col    <= 1'b0;
            dout_vsync <= 1'b0;
            dout_hsync <= 1'b0;
            out_row    <= '0;
            out_col    <= '0;
            frame_err  <= 1'b0;
        end else begin
            row        <= row_nxt;
            col        <= col_nxt;
            h          <= h_nxt;
            vsync_d    <= din_vsync;
            hsync_d    <= din_hsync;
            wr_line    <= buf_wr_nxt;
            buf_wr     <= buf_wr_nxt;
            buf_rd     <= buf_rd_nxt;
            pad_row    <= pad_row_nxt;
            pad_col    <= pad_col_nxt;
            dout_vsync <= dout_vsync_nxt;
            dout_hsync <= line_nxt;
            out_row    <= out_row_nxt;
            out_col    <= out_col_nxt;
            frame_err  <= frame_err_nxt;
        end
    end

endmodule
